// File: rtl/seg_counter.sv
`default_nettype none
// ============================================================================
//  Module   : seg_counter
//  Purpose  : Prescaled hex digit counter with registered seven-segment output.
//  Revision : 1.0  initial release
// ============================================================================
module seg_counter #(
    parameter int DIV        = 4,
    parameter int LAST_DIGIT = 15,
    parameter int ACTIVE_LOW = 0
) (
    input  logic       clk,
    input  logic       reset,
    output logic [6:0] segOut
);

    localparam logic [15:0] c_PCNT_MAX  = 16'(DIV - 1);
    localparam logic [3:0]  c_LAST_DIG  = 4'(LAST_DIGIT);
    localparam logic [6:0]  c_SEG_ZERO  = 7'b0111111;

    logic [15:0] r_pcnt;
    logic [3:0]  r_dig;
    logic [6:0]  r_seg;

    logic        w_step;
    logic [3:0]  w_dig_next;
    logic [6:0]  w_mask;
    logic [6:0]  w_seg_next;
    logic [6:0]  w_seg_reset;

    // Active-high segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            4'hF: s = 7'b1110001;
        endcase
        return s;
    endfunction

    generate
        if (ACTIVE_LOW != 0) begin : g_active_low
            assign w_mask = 7'h7F;
        end else begin : g_active_high
            assign w_mask = 7'h00;
        end
    endgenerate

    assign w_step      = (r_pcnt == c_PCNT_MAX);
    assign w_dig_next  = (r_dig == c_LAST_DIG) ? 4'd0 : r_dig + 4'd1;
    // Decode the next digit so the segment flop lands on the same edge as dig.
    assign w_seg_next  = decode(w_dig_next) ^ w_mask;
    assign w_seg_reset = c_SEG_ZERO ^ w_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcnt <= 16'd0;
            r_dig  <= 4'd0;
            r_seg  <= w_seg_reset;
        end else if (w_step) begin
            r_pcnt <= 16'd0;
            r_dig  <= w_dig_next;
            r_seg  <= w_seg_next;
        end else begin
            r_pcnt <= r_pcnt + 16'd1;
        end
    end

    assign segOut = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_counter
//  Purpose  : Randomized-reset bench for three seg_counter configurations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_counter;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, rst_c;
    logic [6:0] seg_a, seg_b, seg_c;

    int n_checks = 0;
    int n_pass   = 0;

    // Non-reset edges seen since the last reset edge, per instance.
    int n_a = 0, n_b = 0, n_c = 0;

    logic [6:0] seg_table [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    always #5 clk = ~clk;

    seg_counter u_a (.clk(clk), .reset(rst_a), .segOut(seg_a));

    seg_counter #(.DIV(1), .LAST_DIGIT(9), .ACTIVE_LOW(0))
        u_b (.clk(clk), .reset(rst_b), .segOut(seg_b));

    seg_counter #(.DIV(1), .LAST_DIGIT(15), .ACTIVE_LOW(1))
        u_c (.clk(clk), .reset(rst_c), .segOut(seg_c));

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [6:0] model_seg(input int n, input int div,
                                             input int last, input bit alow);
        int digit;
        digit = (n / div) % (last + 1);
        return alow ? ~seg_table[digit] : seg_table[digit];
    endfunction

    task automatic tick(input logic ra, input logic rb, input logic rc);
        rst_a = ra; rst_b = rb; rst_c = rc;
        @(posedge clk);
        n_a = ra ? 0 : n_a + 1;
        n_b = rb ? 0 : n_b + 1;
        n_c = rc ? 0 : n_c + 1;
        #1;
        check("model_a", seg_a, model_seg(n_a, 4, 15, 1'b0));
        check("model_b", seg_b, model_seg(n_b, 1, 9, 1'b0));
        check("model_c", seg_c, model_seg(n_c, 1, 15, 1'b1));
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

        tick(1, 1, 1);
        check("reset_a_e1", seg_a, 7'b0111111);
        check("reset_c_e1", seg_c, 7'b1000000);
        tick(1, 1, 1);
        check("reset_a_e2", seg_a, 7'b0111111);

        // Directed run from release: cadence, wrap and decimal/polarity points.
        for (int e = 1; e <= 64; e++) begin
            tick(0, 0, 0);
            if (e <= 3)  check("cadence_hold", seg_a, 7'b0111111);
            if (e == 4)  check("cadence_e4", seg_a, 7'b0000110);
            if (e == 8)  check("cadence_e8", seg_a, 7'b1011011);
            if (e == 64) check("wrap_e64", seg_a, 7'b0111111);
            if (e == 9)  check("dec_e9", seg_b, 7'b1101111);
            if (e == 10) check("dec_e10", seg_b, 7'b0111111);
            if (e == 1)  check("pol_e1", seg_c, 7'b1111001);
            if (e == 8)  check("pol_e8", seg_c, 7'b0000000);
            if (seg_b == 7'b1110111 || seg_b == 7'b1111100 || seg_b == 7'b0111001 ||
                seg_b == 7'b1011110 || seg_b == 7'b1111001 || seg_b == 7'b1110001)
                check("dec_no_hex", seg_b, 7'b0111111);
        end

        // Reset mid-count at digit 4, pcnt 2.
        tick(1, 0, 0);
        for (int e = 0; e < 18; e++) tick(0, 0, 0);
        check("mid_pre", seg_a, 7'b1100110);
        tick(1, 0, 0);
        check("mid_reset", seg_a, 7'b0111111);
        for (int e = 1; e <= 4; e++) begin
            tick(0, 0, 0);
            check("mid_restart", seg_a, (e < 4) ? 7'b0111111 : 7'b0000110);
        end

        // Randomized resets, including multi-edge holds.
        for (int i = 0; i < 600; i++) begin
            tick(logic'($urandom_range(0, 29) == 0),
                 logic'($urandom_range(0, 19) == 0),
                 logic'($urandom_range(0, 24) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
